multicycle_controller: RTL and testbench

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/cpu_ctrl_pkg.sv | 69 ++++++
 rtl/opcode_classifier.sv | 42 ++++
 rtl/multicycle_controller.sv | 210 +++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multicycle CPU control path: opcodes, FSM states,
// writeback/branch selects, error codes and the opcode class enum.
package cpu_ctrl_pkg;

    localparam logic [4:0] OP_MV   = 5'b00000;
    localparam logic [4:0] OP_ADD  = 5'b00001;
    localparam logic [4:0] OP_SUB  = 5'b00010;
    localparam logic [4:0] OP_CMP  = 5'b00011;
    localparam logic [4:0] OP_LD   = 5'b00100;
    localparam logic [4:0] OP_ST   = 5'b00101;
    localparam logic [4:0] OP_MVI  = 5'b10000;
    localparam logic [4:0] OP_ADDI = 5'b10001;
    localparam logic [4:0] OP_SUBI = 5'b10010;
    localparam logic [4:0] OP_CMPI = 5'b10011;
    localparam logic [4:0] OP_MVHI = 5'b10110;

    // Branch opcodes ignore bit 4, which picks register vs. pc-relative target.
    localparam logic [3:0] BR_J    = 4'b1000;
    localparam logic [3:0] BR_JZ   = 4'b1001;
    localparam logic [3:0] BR_JN   = 4'b1010;
    localparam logic [3:0] BR_CALL = 4'b1100;

    localparam logic [2:0] WB_MEM    = 3'b000;
    localparam logic [2:0] WB_ALU    = 3'b001;
    localparam logic [2:0] WB_PC2    = 3'b010;
    localparam logic [2:0] WB_RY     = 3'b011;
    localparam logic [2:0] WB_IMM8   = 3'b100;
    localparam logic [2:0] WB_HIBYTE = 3'b101;

    localparam logic [1:0] BRSEL_ALWAYS = 2'd0;
    localparam logic [1:0] BRSEL_Z      = 2'd1;
    localparam logic [1:0] BRSEL_N      = 2'd2;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_ILLEGAL = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEM,
        S_WRITEBACK,
        S_HALT
    } state_t;

    typedef enum logic [2:0] {
        CLS_ALU,
        CLS_MEM,
        CLS_BRANCH,
        CLS_MOVE,
        CLS_ILLEGAL
    } opc_class_t;

    function automatic logic [2:0] wb_src_of(input logic [4:0] op);
        logic [2:0] sel;
        sel = WB_ALU;
        case (op)
            OP_LD:   sel = WB_MEM;
            OP_MV:   sel = WB_RY;
            OP_MVI:  sel = WB_IMM8;
            OP_MVHI: sel = WB_HIBYTE;
            default: if (op[3:0] == BR_CALL) sel = WB_PC2;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/opcode_classifier.sv
// Combinational opcode classifier: maps the instruction register opcode onto
// one of the alu / mem / branch / move / illegal classes.
module opcode_classifier
    import cpu_ctrl_pkg::*;
#(
    parameter int OPC_W = 5
) (
    input  logic [OPC_W-1:0] opcode,
    output opc_class_t       opc_class
);

    logic [4:0] op;
    logic       extra_zero;

    assign op = opcode[OPC_W-1:OPC_W-5];

    // Bits beyond the decoded 5-bit field must be zero for a legal opcode.
    generate
        if (OPC_W > 5) begin : g_extra
            assign extra_zero = (opcode[OPC_W-6:0] == '0);
        end else begin : g_no_extra
            assign extra_zero = 1'b1;
        end
    endgenerate

    always_comb begin
        opc_class = CLS_ILLEGAL;
        if (extra_zero) begin
            case (op)
                OP_ADD, OP_SUB, OP_CMP,
                OP_ADDI, OP_SUBI, OP_CMPI: opc_class = CLS_ALU;
                OP_LD, OP_ST:              opc_class = CLS_MEM;
                OP_MV, OP_MVI, OP_MVHI:    opc_class = CLS_MOVE;
                default: begin
                    if (op[3:0] inside {BR_J, BR_JZ, BR_JN, BR_CALL})
                        opc_class = CLS_BRANCH;
                end
            endcase
        end
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle CPU control FSM: fetch, decode, execute, memory and writeback
// sequencing with a memory wait timeout and a sticky HALT state.
module multicycle_controller
    import cpu_ctrl_pkg::*;
#(
    parameter int OPC_W           = 5,
    parameter int TIMEOUT         = 16,
    parameter int HALT_ON_ILLEGAL = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [OPC_W-1:0] opcode,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_sel,
    output logic             pc_en,
    output logic             pc_src,
    output logic             ir_load,
    output logic             reg_we,
    output logic             reg_dst,
    output logic [2:0]       wb_src,
    output logic             alu_op,
    output logic             b_src,
    output logic             ext_sel,
    output logic             nz_we,
    output logic             br_src,
    output logic [1:0]       br_sel,
    output logic             busy,
    output logic             halted,
    output logic [1:0]       err_code
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t     state;
    logic [7:0] wait_cnt;
    logic       pc_en_q;
    logic [4:0] op;
    opc_class_t opc_class;
    logic       wait_expired;

    assign op           = opcode[OPC_W-1:OPC_W-5];
    assign wait_expired = (wait_cnt + 8'd1) == TIMEOUT_CNT;

    opcode_classifier #(.OPC_W(OPC_W)) u_classifier (
        .opcode    (opcode),
        .opc_class (opc_class)
    );

    // IR load and PC increment must coincide with the fetch mem_ready strobe itself.
    assign ir_load = (state == S_FETCH) && mem_ready;
    assign pc_en   = pc_en_q || ir_load;

    // Outputs are registered for the state being entered, so each is cleared by default.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            err_code <= ERR_NONE;
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            mem_sel  <= 1'b0;
            pc_en_q  <= 1'b0;
            pc_src   <= 1'b0;
            reg_we   <= 1'b0;
            reg_dst  <= 1'b0;
            wb_src   <= WB_MEM;
            alu_op   <= 1'b0;
            b_src    <= 1'b0;
            ext_sel  <= 1'b0;
            nz_we    <= 1'b0;
            br_src   <= 1'b0;
            br_sel   <= BRSEL_ALWAYS;
            busy     <= 1'b0;
            halted   <= 1'b0;
        end else begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            mem_sel <= 1'b0;
            pc_en_q <= 1'b0;
            pc_src  <= 1'b0;
            reg_we  <= 1'b0;
            reg_dst <= 1'b0;
            wb_src  <= WB_MEM;
            alu_op  <= 1'b0;
            b_src   <= 1'b0;
            ext_sel <= 1'b0;
            nz_we   <= 1'b0;
            br_src  <= 1'b0;
            br_sel  <= BRSEL_ALWAYS;
            busy    <= 1'b1;
            halted  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_FETCH;
                        wait_cnt <= '0;
                        mem_req  <= 1'b1;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                S_FETCH: begin
                    if (mem_ready) begin
                        state <= S_DECODE;
                    end else if (wait_expired) begin
                        state    <= S_HALT;
                        err_code <= ERR_TIMEOUT;
                        busy     <= 1'b0;
                        halted   <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                        mem_req  <= 1'b1;
                    end
                end
                S_DECODE: begin
                    if (opc_class == CLS_ILLEGAL) begin
                        if (HALT_ON_ILLEGAL != 0) begin
                            state    <= S_HALT;
                            err_code <= ERR_ILLEGAL;
                            busy     <= 1'b0;
                            halted   <= 1'b1;
                        end else begin
                            state    <= S_FETCH;
                            wait_cnt <= '0;
                            mem_req  <= 1'b1;
                        end
                    end else begin
                        state <= S_EXECUTE;
                        case (opc_class)
                            CLS_ALU: begin
                                alu_op <= op inside {OP_SUB, OP_CMP, OP_SUBI, OP_CMPI};
                                b_src  <= op inside {OP_ADDI, OP_SUBI, OP_CMPI};
                                nz_we  <= 1'b1;
                            end
                            CLS_BRANCH: begin
                                pc_en_q <= 1'b1;
                                pc_src  <= 1'b1;
                                br_src  <= op[4];
                                ext_sel <= op[4];
                                br_sel  <= (op[3:0] == BR_JZ) ? BRSEL_Z :
                                           (op[3:0] == BR_JN) ? BRSEL_N : BRSEL_ALWAYS;
                            end
                            CLS_MOVE: b_src <= (op == OP_MVHI);
                            default: ;
                        endcase
                    end
                end
                S_EXECUTE: begin
                    if (opc_class == CLS_MEM) begin
                        state    <= S_MEM;
                        wait_cnt <= '0;
                        mem_req  <= 1'b1;
                        mem_sel  <= 1'b1;
                        mem_we   <= (op == OP_ST);
                    end else if (op inside {OP_CMP, OP_CMPI} ||
                                 (opc_class == CLS_BRANCH && op[3:0] != BR_CALL)) begin
                        state    <= S_FETCH;
                        wait_cnt <= '0;
                        mem_req  <= 1'b1;
                    end else begin
                        state   <= S_WRITEBACK;
                        reg_we  <= 1'b1;
                        reg_dst <= (opc_class == CLS_BRANCH);
                        wb_src  <= wb_src_of(op);
                    end
                end
                S_MEM: begin
                    if (mem_ready) begin
                        if (op == OP_ST) begin
                            state    <= S_FETCH;
                            wait_cnt <= '0;
                            mem_req  <= 1'b1;
                        end else begin
                            state  <= S_WRITEBACK;
                            reg_we <= 1'b1;
                            wb_src <= WB_MEM;
                        end
                    end else if (wait_expired) begin
                        state    <= S_HALT;
                        err_code <= ERR_TIMEOUT;
                        busy     <= 1'b0;
                        halted   <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                        mem_req  <= 1'b1;
                        mem_sel  <= 1'b1;
                        mem_we   <= (op == OP_ST);
                    end
                end
                S_WRITEBACK: begin
                    state    <= S_FETCH;
                    wait_cnt <= '0;
                    mem_req  <= 1'b1;
                end
                S_HALT: begin
                    busy   <= 1'b0;
                    halted <= 1'b1;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: per-instruction expected cycle traces are
// built from the controller's rules and compared against two parameterisations.
module tb_multicycle_controller;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       mem_sel;
        logic       pc_en;
        logic       pc_src;
        logic       ir_load;
        logic       reg_we;
        logic       reg_dst;
        logic [2:0] wb_src;
        logic       alu_op;
        logic       b_src;
        logic       ext_sel;
        logic       nz_we;
        logic       br_src;
        logic [1:0] br_sel;
        logic       busy;
        logic       halted;
        logic [1:0] err_code;
    } outv_t;

    typedef struct packed {
        logic       rst;
        logic       start;
        logic       ready;
        logic [4:0] opc;
    } inv_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [4:0] opcode = 5'b0;
    logic       mem_ready = 1'b0;

    outv_t obs [2];
    int    sel;
    int    n_vec;
    int    n_err;

    int         mdl_timeout;
    bit         mdl_hoi;
    bit         mdl_halted;
    logic [1:0] mdl_err;

    inv_t  q_in  [$];
    outv_t q_exp [$];
    string q_tag [$];

    always #5 clk = ~clk;

    // Instance 0: TIMEOUT=4, halts on illegal; instance 1: defaults but treats illegal as NOP.
    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic       mem_req, mem_we, mem_sel, pc_en, pc_src, ir_load;
        logic       reg_we, reg_dst, alu_op, b_src, ext_sel, nz_we, br_src;
        logic       busy, halted;
        logic [2:0] wb_src;
        logic [1:0] br_sel, err_code;

        multicycle_controller #(
            .OPC_W           (5),
            .TIMEOUT         (g == 0 ? 4 : 16),
            .HALT_ON_ILLEGAL (g == 0 ? 1 : 0)
        ) dut (
            .clk       (clk),
            .reset     (reset),
            .start     (start),
            .opcode    (opcode),
            .mem_ready (mem_ready),
            .mem_req   (mem_req),
            .mem_we    (mem_we),
            .mem_sel   (mem_sel),
            .pc_en     (pc_en),
            .pc_src    (pc_src),
            .ir_load   (ir_load),
            .reg_we    (reg_we),
            .reg_dst   (reg_dst),
            .wb_src    (wb_src),
            .alu_op    (alu_op),
            .b_src     (b_src),
            .ext_sel   (ext_sel),
            .nz_we     (nz_we),
            .br_src    (br_src),
            .br_sel    (br_sel),
            .busy      (busy),
            .halted    (halted),
            .err_code  (err_code)
        );

        assign obs[g] = {mem_req, mem_we, mem_sel, pc_en, pc_src, ir_load, reg_we, reg_dst,
                         wb_src, alu_op, b_src, ext_sel, nz_we, br_src, br_sel,
                         busy, halted, err_code};
    end

    function automatic bit rndBit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic inv_t mkIn(input bit rst, input bit st, input bit rdy, input logic [4:0] opc);
        inv_t i;
        i.rst   = rst;
        i.start = st;
        i.ready = rdy;
        i.opc   = opc;
        return i;
    endfunction

    function automatic outv_t busyVec();
        outv_t e;
        e      = '0;
        e.busy = 1'b1;
        return e;
    endfunction

    // 0 alu, 1 mem, 2 branch, 3 move, 4 illegal
    function automatic int opClass(input logic [4:0] op);
        case (op)
            5'b00001, 5'b00010, 5'b00011, 5'b10001, 5'b10010, 5'b10011: return 0;
            5'b00100, 5'b00101: return 1;
            5'b01000, 5'b11000, 5'b01001, 5'b11001,
            5'b01010, 5'b11010, 5'b01100, 5'b11100: return 2;
            5'b00000, 5'b10000, 5'b10110: return 3;
            default: return 4;
        endcase
    endfunction

    function automatic logic [2:0] wbFor(input logic [4:0] op);
        case (op)
            5'b00100: return 3'b000;
            5'b00000: return 3'b011;
            5'b10000: return 3'b100;
            5'b10110: return 3'b101;
            5'b01100, 5'b11100: return 3'b010;
            default: return 3'b001;
        endcase
    endfunction

    task automatic pushCycle(input inv_t i, input outv_t e, input string tag);
        q_in.push_back(i);
        q_exp.push_back(e);
        q_tag.push_back(tag);
    endtask

    task automatic modelReset();
        pushCycle(mkIn(1'b1, 1'b0, rndBit(), 5'($urandom)), '0, "reset");
        mdl_halted = 1'b0;
        mdl_err    = 2'd0;
    endtask

    task automatic modelIdle(input bit st);
        pushCycle(mkIn(1'b0, st, rndBit(), 5'($urandom)), '0, st ? "idle_start" : "idle");
    endtask

    task automatic modelHalt(input int n);
        outv_t e;
        e          = '0;
        e.halted   = 1'b1;
        e.err_code = mdl_err;
        for (int k = 0; k < n; k++)
            pushCycle(mkIn(1'b0, 1'b1, rndBit(), 5'($urandom)), e, "halt");
    endtask

    // One memory access (fetch or data) that sees mem_ready after d idle cycles.
    task automatic memPhase(input logic [4:0] opc, input bit data, input bit wr,
                            input int d, output bit ok);
        outv_t e;
        int    waits;
        waits     = (d < mdl_timeout) ? d : mdl_timeout;
        e         = busyVec();
        e.mem_req = 1'b1;
        e.mem_sel = data;
        e.mem_we  = wr;
        for (int k = 0; k < waits; k++)
            pushCycle(mkIn(1'b0, 1'b0, 1'b0, opc), e, data ? "mem_wait" : "fetch_wait");
        if (d < mdl_timeout) begin
            if (!data) begin
                e.ir_load = 1'b1;
                e.pc_en   = 1'b1;
            end
            pushCycle(mkIn(1'b0, 1'b0, 1'b1, opc), e, data ? "mem_done" : "fetch_done");
            ok = 1'b1;
        end else begin
            mdl_halted = 1'b1;
            mdl_err    = 2'd2;
            ok         = 1'b0;
        end
    endtask

    task automatic modelInstr(input logic [4:0] op, input int fd, input int md);
        outv_t e;
        bit    ok;
        int    cls;
        if (mdl_halted) return;
        memPhase(op, 1'b0, 1'b0, fd, ok);
        if (!ok) return;
        pushCycle(mkIn(1'b0, 1'b0, rndBit(), op), busyVec(), "decode");
        cls = opClass(op);
        if (cls == 4) begin
            if (mdl_hoi) begin
                mdl_halted = 1'b1;
                mdl_err    = 2'd1;
            end
            return;
        end
        e = busyVec();
        case (cls)
            0: begin
                e.nz_we  = 1'b1;
                e.alu_op = op inside {5'b00010, 5'b00011, 5'b10010, 5'b10011};
                e.b_src  = op inside {5'b10001, 5'b10010, 5'b10011};
            end
            2: begin
                e.pc_en   = 1'b1;
                e.pc_src  = 1'b1;
                e.br_src  = op[4];
                e.ext_sel = op[4];
                e.br_sel  = (op[3:0] == 4'b1001) ? 2'd1 : (op[3:0] == 4'b1010) ? 2'd2 : 2'd0;
            end
            3: e.b_src = (op == 5'b10110);
            default: ;
        endcase
        pushCycle(mkIn(1'b0, 1'b0, rndBit(), op), e, "execute");
        if (op inside {5'b00011, 5'b10011} || (cls == 2 && op[2] == 1'b0)) return;
        if (cls == 1) begin
            memPhase(op, 1'b1, op == 5'b00101, md, ok);
            if (!ok || op == 5'b00101) return;
        end
        e         = busyVec();
        e.reg_we  = 1'b1;
        e.reg_dst = (cls == 2);
        e.wb_src  = wbFor(op);
        pushCycle(mkIn(1'b0, 1'b0, rndBit(), op), e, "writeback");
    endtask

    task automatic applyStimulus(input inv_t i);
        @(posedge clk);
        #1;
        reset     = i.rst;
        start     = i.start;
        mem_ready = i.ready;
        opcode    = i.opc;
    endtask

    task automatic checkOutput(input outv_t exp, input string tag);
        @(negedge clk);
        n_vec++;
        assert (obs[sel] === exp)
        else begin
            n_err++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs[sel], exp);
        end
    endtask

    task automatic runQueue();
        inv_t  i;
        outv_t e;
        string t;
        while (q_in.size() > 0) begin
            i = q_in.pop_front();
            e = q_exp.pop_front();
            t = q_tag.pop_front();
            applyStimulus(i);
            checkOutput(e, t);
        end
    endtask

    task automatic randomPrograms(input int n);
        logic [4:0] legal [15];
        logic [4:0] op;
        int         fd;
        int         md;
        legal = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00101, 5'b01000,
                  5'b11001, 5'b01010, 5'b01100, 5'b10000, 5'b10001, 5'b10010, 5'b10011,
                  5'b10110};
        for (int p = 0; p < n; p++) begin
            modelReset();
            if (rndBit()) modelIdle(1'b0);
            modelIdle(1'b1);
            for (int k = 0; k < 6; k++) begin
                op = ($urandom_range(0, 9) == 0) ? 5'($urandom) : legal[$urandom_range(0, 14)];
                fd = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, mdl_timeout + 1))
                                                 : int'($urandom_range(0, 2));
                md = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, mdl_timeout + 1))
                                                 : int'($urandom_range(0, 2));
                modelInstr(op, fd, md);
            end
            if (mdl_halted) modelHalt(2);
            runQueue();
        end
    endtask

    initial begin
        n_vec       = 0;
        n_err       = 0;
        sel         = 0;
        mdl_timeout = 4;
        mdl_hoi     = 1'b1;
        mdl_halted  = 1'b0;
        mdl_err     = 2'd0;

        // Directed program: add with fetch ready on the last allowed wait cycle,
        // ld/st/call/branches/moves, then a st whose memory never answers.
        modelReset();
        modelIdle(1'b0);
        modelIdle(1'b1);
        modelInstr(5'b00001, 3, 0);
        modelInstr(5'b00100, 0, 0);
        modelInstr(5'b00101, 1, 2);
        modelInstr(5'b11100, 0, 0);
        modelInstr(5'b01001, 0, 0);
        modelInstr(5'b11010, 1, 0);
        modelInstr(5'b01000, 0, 0);
        modelInstr(5'b00000, 0, 0);
        modelInstr(5'b10000, 2, 0);
        modelInstr(5'b10110, 0, 0);
        modelInstr(5'b10011, 0, 0);
        modelInstr(5'b00010, 0, 0);
        modelInstr(5'b10001, 0, 0);
        modelInstr(5'b10010, 0, 0);
        modelInstr(5'b00011, 0, 0);
        modelInstr(5'b00100, 0, 3);
        modelInstr(5'b00101, 0, 4);
        modelHalt(3);
        runQueue();

        // Illegal opcode halts with err_code 1.
        modelReset();
        modelIdle(1'b1);
        modelInstr(5'b01111, 0, 0);
        modelHalt(3);
        runQueue();

        // Reset asserted while a ld is waiting in MEM, then a clean restart.
        modelReset();
        modelIdle(1'b1);
        modelInstr(5'b00100, 0, 3);
        repeat (3) begin
            q_in.delete(q_in.size() - 1);
            q_exp.delete(q_exp.size() - 1);
            q_tag.delete(q_tag.size() - 1);
        end
        modelReset();
        modelIdle(1'b1);
        modelInstr(5'b00001, 0, 0);
        runQueue();

        // Fetch that never completes.
        modelReset();
        modelIdle(1'b1);
        modelInstr(5'b00000, 4, 0);
        modelHalt(2);
        runQueue();

        randomPrograms(40);

        // Second instance: illegal opcode behaves as a NOP, longer timeout.
        sel         = 1;
        mdl_timeout = 16;
        mdl_hoi     = 1'b0;
        modelReset();
        modelIdle(1'b1);
        modelInstr(5'b01111, 0, 0);
        modelInstr(5'b00001, 1, 0);
        modelInstr(5'b00100, 0, 15);
        runQueue();

        randomPrograms(30);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
